count_dir_ctrl: RTL and testbench

- Sequencing controller for the parameterised up/down counter `Param_count` (ports `clk`, `rst`, `UorD`, `count`).
- Drives the counter's `rst` and `UorD`, and reads `count` back.
- Makes the counter bounce between a programmable low and high limit with no wrap-around.
- Counts completed bounce cycles and flags configuration errors and counter/controller desynchronisation.

---
 rtl/count_ctrl_pkg.sv | 27 ++
 rtl/Param_count.sv | 24 ++
 rtl/count_dir_ctrl.sv | 162 ++++++++++++++++
 tb/tb_count_dir_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the up/down counter sequencing controller.
//   dir_state_t : controller state (IDLE, UP, DOWN)
//   DEF_LENGTH  : default counter width
//   DEF_CYC_W   : default bounce-cycle counter width
//   sat_inc     : increment that sticks at the all-ones value of a w-bit field
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_state_t;

  localparam int DEF_LENGTH = 4;
  localparam int DEF_CYC_W  = 8;

  // Works on a 32-bit carrier so one function serves any field width up to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    if (w >= 32)
      max_v = '1;
    else
      max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/Param_count.sv
// Parameterised up/down counter driven by count_dir_ctrl.
//   clk   : clock
//   rst   : synchronous active-high clear to 0
//   UorD  : 1 = count up, 0 = count down (wraps modulo 2^length)
//   count : current value
module Param_count #(
  parameter int length = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              UorD,
  output logic [length-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (UorD)
      count <= count + length'(1);
    else
      count <= count - length'(1);
  end

endmodule

// File: rtl/count_dir_ctrl.sv
// Sequencing controller that makes an external up/down counter bounce between
// a programmable low and high limit without wrapping.
//   clk, rst        : clock, synchronous active-high reset
//   start, stop     : begin bouncing / halt at next edge
//   lo_lim, hi_lim  : turn points, captured when start is accepted
//   count           : counter value fed back
//   cnt_rst, UorD   : drive the counter's rst and UorD
//   turn            : one-cycle pulse while count sits on a limit
//   bounces         : completed lo->hi->lo cycles, saturating
//   busy            : high while bouncing
//   cfg_err         : sticky, start rejected for lo_lim >= hi_lim
//   sync_err        : sticky, count disagreed with the internal shadow value
module count_dir_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int LENGTH = DEF_LENGTH,
  parameter int CYC_W  = DEF_CYC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [LENGTH-1:0] lo_lim,
  input  logic [LENGTH-1:0] hi_lim,
  input  logic [LENGTH-1:0] count,
  output logic              cnt_rst,
  output logic              UorD,
  output logic              turn,
  output logic [CYC_W-1:0]  bounces,
  output logic              busy,
  output logic              cfg_err,
  output logic              sync_err
);

  dir_state_t        state_reg, state_next;
  logic [LENGTH-1:0] lo_reg, lo_next;
  logic [LENGTH-1:0] hi_reg, hi_next;
  logic [LENGTH-1:0] exp_reg, exp_next;
  logic              cnt_rst_reg, cnt_rst_next;
  logic              uord_reg, uord_next;
  logic              turn_reg, turn_next;
  logic [CYC_W-1:0]  bounces_reg, bounces_next;
  logic              busy_reg, busy_next;
  logic              cfg_err_reg, cfg_err_next;
  logic              sync_err_reg, sync_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      lo_reg       <= '0;
      hi_reg       <= '0;
      exp_reg      <= '0;
      cnt_rst_reg  <= 1'b1;
      uord_reg     <= 1'b1;
      turn_reg     <= 1'b0;
      bounces_reg  <= '0;
      busy_reg     <= 1'b0;
      cfg_err_reg  <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lo_reg       <= lo_next;
      hi_reg       <= hi_next;
      exp_reg      <= exp_next;
      cnt_rst_reg  <= cnt_rst_next;
      uord_reg     <= uord_next;
      turn_reg     <= turn_next;
      bounces_reg  <= bounces_next;
      busy_reg     <= busy_next;
      cfg_err_reg  <= cfg_err_next;
      sync_err_reg <= sync_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lo_next       = lo_reg;
    hi_next       = hi_reg;
    exp_next      = exp_reg;
    cnt_rst_next  = cnt_rst_reg;
    uord_next     = uord_reg;
    turn_next     = 1'b0;
    bounces_next  = bounces_reg;
    busy_next     = busy_reg;
    cfg_err_next  = cfg_err_reg;
    sync_err_next = sync_err_reg;

    // Shadow copy of the counter: follows exactly what the counter will do
    // with the cnt_rst/UorD values currently being driven.
    if (!cnt_rst_reg)
      exp_next = uord_reg ? exp_reg + LENGTH'(1) : exp_reg - LENGTH'(1);

    if (state_reg != IDLE && count != exp_reg)
      sync_err_next = 1'b1;

    case (state_reg)
      IDLE: begin
        cnt_rst_next = 1'b1;
        uord_next    = 1'b1;
        busy_next    = 1'b0;
        if (start && !stop) begin
          if (lo_lim < hi_lim) begin
            lo_next      = lo_lim;
            hi_next      = hi_lim;
            exp_next     = '0;
            cnt_rst_next = 1'b0;
            uord_next    = 1'b1;
            busy_next    = 1'b1;
            state_next   = UP;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end

      // Turns are decided one step early so the counter lands exactly on
      // the limit in the cycle turn is high.
      UP: begin
        if (stop) begin
          state_next   = IDLE;
          cnt_rst_next = 1'b1;
          uord_next    = 1'b1;
          busy_next    = 1'b0;
        end else if (count == hi_reg - LENGTH'(1)) begin
          uord_next  = 1'b0;
          turn_next  = 1'b1;
          state_next = DOWN;
        end
      end

      DOWN: begin
        if (stop) begin
          state_next   = IDLE;
          cnt_rst_next = 1'b1;
          uord_next    = 1'b1;
          busy_next    = 1'b0;
        end else if (count == lo_reg + LENGTH'(1)) begin
          uord_next    = 1'b1;
          turn_next    = 1'b1;
          bounces_next = CYC_W'(sat_inc(32'(bounces_reg), CYC_W));
          state_next   = UP;
        end
      end

      default: begin
        state_next   = IDLE;
        cnt_rst_next = 1'b1;
        uord_next    = 1'b1;
        busy_next    = 1'b0;
      end
    endcase
  end

  assign cnt_rst  = cnt_rst_reg;
  assign UorD     = uord_reg;
  assign turn     = turn_reg;
  assign bounces  = bounces_reg;
  assign busy     = busy_reg;
  assign cfg_err  = cfg_err_reg;
  assign sync_err = sync_err_reg;

endmodule

// File: tb/tb_count_dir_ctrl.sv
// Closed-loop bench: count_dir_ctrl driving Param_count, with a per-cycle
// scoreboard of expected counter/controller behaviour.
module tb_count_dir_ctrl;

  localparam int LENGTH = 4;
  localparam int CYC_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [LENGTH-1:0] lo_lim;
  logic [LENGTH-1:0] hi_lim;
  logic [LENGTH-1:0] cnt_count;
  logic [LENGTH-1:0] dut_count;
  logic              force_en;
  logic              cnt_rst;
  logic              UorD;
  logic              turn;
  logic [CYC_W-1:0]  bounces;
  logic              busy;
  logic              cfg_err;
  logic              sync_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [LENGTH-1:0] count;
    logic              turn;
    logic              uord;
    logic [CYC_W-1:0]  bounces;
  } exp_t;

  exp_t sb_q[$];

  // Model state: counter value, direction, bounce count, limits
  int m_c, m_up, m_b, m_lo, m_hi;

  always #5 clk = ~clk;

  assign dut_count = force_en ? 4'd9 : cnt_count;

  count_dir_ctrl #(.LENGTH(LENGTH), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .count(dut_count),
    .cnt_rst(cnt_rst), .UorD(UorD), .turn(turn), .bounces(bounces),
    .busy(busy), .cfg_err(cfg_err), .sync_err(sync_err)
  );

  Param_count #(.length(LENGTH)) u_cnt (
    .clk(clk), .rst(cnt_rst), .UorD(UorD), .count(cnt_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_init(input int lo, input int hi, input int b0);
    m_c = 0; m_up = 1; m_b = b0; m_lo = lo; m_hi = hi;
  endtask

  // Bounce behaviour stated in terms of counter values: turn high on the
  // cycle the counter sits at hi, or at lo after descending.
  task automatic model_push(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.turn = 1'b0;
      if (m_up != 0) begin
        m_c++;
        if (m_c == m_hi) begin m_up = 0; e.turn = 1'b1; end
      end else begin
        m_c--;
        if (m_c == m_lo) begin
          m_up = 1; e.turn = 1'b1;
          if (m_b < 255) m_b++;
        end
      end
      e.count   = LENGTH'(m_c);
      e.uord    = (m_up != 0);
      e.bounces = CYC_W'(m_b);
      sb_q.push_back(e);
    end
  endtask

  task automatic run_check(input int n, input logic exp_sync);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        e = sb_q.pop_front();
        $display("[TB] cyc count=%0d turn=%0d UorD=%0d bounces=%0d busy=%0d sync=%0d",
                 cnt_count, turn, UorD, bounces, busy, sync_err);
        chk("count", cnt_count, e.count);
        chk("turn", turn, e.turn);
        chk("UorD", UorD, e.uord);
        chk("bounces", bounces, e.bounces);
        chk("busy", busy, 1);
        chk("sync_err", sync_err, exp_sync);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cnt_rst"}, cnt_rst, 1);
    chk({tag, "_UorD"}, UorD, 1);
    chk({tag, "_turn"}, turn, 0);
    chk({tag, "_bounces"}, bounces, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
  endtask

  task automatic do_start(input int lo, input int hi);
    lo_lim = LENGTH'(lo); hi_lim = LENGTH'(hi); start = 1'b1;
    tick();
    start = 1'b0;
    $display("[TB] start lo=%0d hi=%0d busy=%0d cnt_rst=%0d count=%0d cfg_err=%0d",
             lo, hi, busy, cnt_rst, cnt_count, cfg_err);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; force_en = 1'b0;
    lo_lim = '0; hi_lim = '0;
    tick(); tick();
    check_reset_vals("reset");
    chk("reset_count", cnt_count, 0);
    rst = 1'b0;
    tick();

    // Basic bounce 2..5, then stop while count = 4 going up (coincides
    // with a pending up-turn; stop must win).
    do_start(2, 5);
    chk("start_busy", busy, 1);
    chk("start_cnt_rst", cnt_rst, 0);
    chk("start_count", cnt_count, 0);
    model_init(2, 5, 0);
    model_push(22);
    run_check(22, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    $display("[TB] stop busy=%0d cnt_rst=%0d turn=%0d count=%0d", busy, cnt_rst, turn, cnt_count);
    chk("stop_busy", busy, 0);
    chk("stop_cnt_rst", cnt_rst, 1);
    chk("stop_turn", turn, 0);
    chk("stop_count", cnt_count, 5);
    chk("stop_bounces", bounces, 3);
    tick();
    chk("stop_count_zero", cnt_count, 0);
    chk("stop_bounces_held", bounces, 3);

    // Adjacent limits: turn every cycle; limit changes while busy ignored.
    do_start(1, 2);
    chk("adj_busy", busy, 1);
    lo_lim = 4'd0; hi_lim = 4'd15;
    model_init(1, 2, 3);
    model_push(6);
    run_check(6, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("adj_stop_busy", busy, 0);
    tick();
    chk("adj_idle_count", cnt_count, 0);
    chk("adj_bounces", bounces, 5);

    // Rejected start: lo >= hi.
    do_start(7, 3);
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_busy", busy, 0);
    chk("cfg_cnt_rst", cnt_rst, 1);
    tick();
    chk("cfg_count", cnt_count, 0);

    // start with stop in IDLE: nothing happens.
    lo_lim = 4'd2; hi_lim = 4'd5; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_cnt_rst", cnt_rst, 1);
    chk("ss_cfg_err", cfg_err, 1);

    // Valid start after error; then rst while in DOWN.
    do_start(1, 3);
    model_init(1, 3, 5);
    model_push(8);
    run_check(8, 1'b0);
    chk("cfg_err_sticky", cfg_err, 1);
    rst = 1'b1;
    tick();
    $display("[TB] rst_in_down busy=%0d UorD=%0d bounces=%0d count=%0d", busy, UorD, bounces, cnt_count);
    check_reset_vals("rst_down");
    chk("rst_down_count", cnt_count, 1);
    rst = 1'b0;
    tick();
    chk("rst_down_count_zero", cnt_count, 0);

    // start+stop with bad limits must leave cfg_err clear.
    lo_lim = 4'd7; hi_lim = 4'd3; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_bad_cfg_err", cfg_err, 0);
    chk("ss_bad_busy", busy, 0);

    // Full range 0..15, never wraps.
    do_start(0, 15);
    model_init(0, 15, 0);
    model_push(34);
    run_check(34, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("full_idle_count", cnt_count, 0);
    chk("full_bounces", bounces, 1);

    // Desync: controller sees 9 for one cycle.
    do_start(2, 5);
    model_init(2, 5, 1);
    model_push(6);
    run_check(6, 1'b0);
    force_en = 1'b1;
    model_push(1);
    run_check(1, 1'b1);
    force_en = 1'b0;
    model_push(6);
    run_check(6, 1'b1);
    rst = 1'b1;
    tick();
    check_reset_vals("rst_sync");
    rst = 1'b0;
    tick();
    chk("rst_sync_count", cnt_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
